// File: rtl/devil_snoop_scheduler.sv
// Snoop sequencer for the devil_in_fpga engine: filters ACE AC-channel snoops by window/type,
// delays and dispatches hits to the engine, routes misses to the default responder.
module devil_snoop_scheduler #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_ACE_ADDR_WIDTH   = 32
) (
    input  logic                          ace_aclk,
    input  logic                          ace_areset,
    input  logic                          i_acvalid,
    output logic                          o_acready,
    input  logic [C_ACE_ADDR_WIDTH-1:0]   i_acaddr,
    input  logic [3:0]                    i_acsnoop,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] i_control_reg,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] i_delay_reg,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] i_acsnoop_reg,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] i_base_addr_reg,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] i_addr_size_reg,
    output logic                          o_dev_start,
    output logic [C_ACE_ADDR_WIDTH-1:0]   o_dev_addr,
    output logic [3:0]                    o_dev_snoop,
    input  logic                          i_dev_done,
    output logic                          o_byp_valid,
    output logic [3:0]                    o_byp_snoop,
    input  logic                          i_byp_ready,
    output logic [C_S_AXI_DATA_WIDTH-1:0] o_write_status_reg,
    output logic [2:0]                    o_fsm_state
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARMED  = 3'd1,
        ST_DELAY  = 3'd2,
        ST_ATTACK = 3'd3,
        ST_BYPASS = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    state_t                        state;
    logic                          acready;
    logic                          dev_start;
    logic                          byp_valid;
    logic [C_ACE_ADDR_WIDTH-1:0]   cap_addr;
    logic [3:0]                    cap_snoop;
    logic [C_S_AXI_DATA_WIDTH-1:0] delay_cnt;
    logic [15:0]                   hit_count;
    logic                          fired;
    logic                          aborted;

    logic        enable;
    logic [1:0]  mode;
    logic        clear;
    logic        mode_active;
    logic        handshake;
    logic        type_match;
    logic        win_hit;
    logic        hit;
    logic [32:0] addr_ext;
    logic [32:0] base_ext;
    logic [32:0] limit_ext;
    logic        enter_attack;
    logic        set_fired;
    logic        set_aborted;
    logic        unused_cfg;

    assign enable      = i_control_reg[0];
    assign mode        = i_control_reg[2:1];
    assign clear       = i_control_reg[3];
    assign mode_active = enable && (mode == 2'b01 || mode == 2'b10);
    assign handshake   = i_acvalid && acready;
    assign unused_cfg  = ^{i_control_reg[C_S_AXI_DATA_WIDTH-1:4], i_acsnoop_reg[C_S_AXI_DATA_WIDTH-1:5]};

    // Window limit is formed in 33 bits so a window touching the top of memory never wraps to 0.
    always_comb begin
        addr_ext   = {1'b0, i_acaddr[31:0]};
        base_ext   = {1'b0, i_base_addr_reg[31:0]};
        limit_ext  = base_ext + {1'b0, i_addr_size_reg[31:0]};
        type_match = i_acsnoop_reg[4] || (i_acsnoop == i_acsnoop_reg[3:0]);
        win_hit    = (i_addr_size_reg[31:0] != 32'd0) && (addr_ext >= base_ext) && (addr_ext < limit_ext);
        hit        = type_match && win_hit;
    end

    always_comb begin
        enter_attack = 1'b0;
        set_fired    = 1'b0;
        set_aborted  = 1'b0;
        case (state)
            ST_ARMED:  enter_attack = handshake && hit && (i_delay_reg == '0);
            ST_DELAY: begin
                set_aborted  = !mode_active;
                enter_attack = mode_active && (delay_cnt == C_S_AXI_DATA_WIDTH'(1));
            end
            ST_ATTACK: set_fired = i_dev_done && (mode == 2'b01);
            default: ;
        endcase
    end

    always_ff @(posedge ace_aclk or posedge ace_areset) begin
        if (ace_areset) begin
            state     <= ST_IDLE;
            acready   <= 1'b0;
            dev_start <= 1'b0;
            byp_valid <= 1'b0;
            cap_addr  <= '0;
            cap_snoop <= '0;
            delay_cnt <= '0;
            hit_count <= '0;
            fired     <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            dev_start <= 1'b0;

            if (clear) begin
                hit_count <= '0;
                fired     <= 1'b0;
                aborted   <= 1'b0;
            end else begin
                if (enter_attack && hit_count != 16'hFFFF)
                    hit_count <= hit_count + 16'd1;
                if (set_fired)
                    fired <= 1'b1;
                if (set_aborted)
                    aborted <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (mode_active) begin
                        state   <= ST_ARMED;
                        acready <= 1'b1;
                    end
                end
                ST_ARMED: begin
                    // A handshake presented in the same cycle enable drops is still accepted.
                    if (handshake) begin
                        cap_addr  <= i_acaddr;
                        cap_snoop <= i_acsnoop;
                        acready   <= 1'b0;
                        if (!hit) begin
                            state     <= ST_BYPASS;
                            byp_valid <= 1'b1;
                        end else if (i_delay_reg == '0) begin
                            state     <= ST_ATTACK;
                            dev_start <= 1'b1;
                        end else begin
                            state     <= ST_DELAY;
                            delay_cnt <= i_delay_reg;
                        end
                    end else if (!mode_active) begin
                        state   <= ST_IDLE;
                        acready <= 1'b0;
                    end
                end
                ST_DELAY: begin
                    if (!mode_active) begin
                        state     <= ST_BYPASS;
                        byp_valid <= 1'b1;
                    end else if (delay_cnt == C_S_AXI_DATA_WIDTH'(1)) begin
                        state     <= ST_ATTACK;
                        dev_start <= 1'b1;
                    end else begin
                        delay_cnt <= delay_cnt - C_S_AXI_DATA_WIDTH'(1);
                    end
                end
                ST_ATTACK: begin
                    if (i_dev_done) begin
                        if (mode == 2'b01) begin
                            state <= ST_DONE;
                        end else if (mode_active) begin
                            state   <= ST_ARMED;
                            acready <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_BYPASS: begin
                    if (i_byp_ready) begin
                        byp_valid <= 1'b0;
                        if (mode_active) begin
                            state   <= ST_ARMED;
                            acready <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_DONE: begin
                    if (!enable || mode == 2'b00 || clear)
                        state <= ST_IDLE;
                end
                default: begin
                    state     <= ST_IDLE;
                    acready   <= 1'b0;
                    byp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_acready          = acready;
    assign o_dev_start        = dev_start;
    assign o_dev_addr         = cap_addr;
    assign o_dev_snoop        = cap_snoop;
    assign o_byp_valid        = byp_valid;
    assign o_byp_snoop        = cap_snoop;
    assign o_fsm_state        = state;
    assign o_write_status_reg = C_S_AXI_DATA_WIDTH'({hit_count, 12'd0, aborted, fired,
                                                      state == ST_ATTACK, state == ST_ARMED});

endmodule

// File: tb/tb_devil_snoop_scheduler.sv
// Directed bench for devil_snoop_scheduler: one task per scenario, inline checks on the falling edge.
module tb_devil_snoop_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        acvalid;
    logic        acready;
    logic [31:0] acaddr;
    logic [3:0]  acsnoop;
    logic [31:0] control_reg;
    logic [31:0] delay_reg;
    logic [31:0] acsnoop_reg;
    logic [31:0] base_reg;
    logic [31:0] size_reg;
    logic        dev_start;
    logic [31:0] dev_addr;
    logic [3:0]  dev_snoop;
    logic        dev_done;
    logic        byp_valid;
    logic [3:0]  byp_snoop;
    logic        byp_ready;
    logic [31:0] status;
    logic [2:0]  fsm_state;

    int unsigned nvec = 0;
    int unsigned nerr = 0;

    always #5 clk = ~clk;

    devil_snoop_scheduler #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_ACE_ADDR_WIDTH   (32)
    ) dut (
        .ace_aclk           (clk),
        .ace_areset         (rst),
        .i_acvalid          (acvalid),
        .o_acready          (acready),
        .i_acaddr           (acaddr),
        .i_acsnoop          (acsnoop),
        .i_control_reg      (control_reg),
        .i_delay_reg        (delay_reg),
        .i_acsnoop_reg      (acsnoop_reg),
        .i_base_addr_reg    (base_reg),
        .i_addr_size_reg    (size_reg),
        .o_dev_start        (dev_start),
        .o_dev_addr         (dev_addr),
        .o_dev_snoop        (dev_snoop),
        .i_dev_done         (dev_done),
        .o_byp_valid        (byp_valid),
        .o_byp_snoop        (byp_snoop),
        .i_byp_ready        (byp_ready),
        .o_write_status_reg (status),
        .o_fsm_state        (fsm_state)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; acvalid = 1'b0; acaddr = '0; acsnoop = '0; control_reg = '0;
        delay_reg = 32'd5; acsnoop_reg = 32'h1; base_reg = 32'h1000; size_reg = 32'h100;
        dev_done = 1'b0; byp_ready = 1'b0;
        repeat (3) tick();
        nvec++; if (fsm_state !== 3'd0) begin nerr++; $display("FAIL rst_state: got %0d want 0", fsm_state); end
        nvec++; if (acready !== 1'b0) begin nerr++; $display("FAIL rst_acready: got %b want 0", acready); end
        nvec++; if (dev_start !== 1'b0 || byp_valid !== 1'b0) begin nerr++; $display("FAIL rst_pulses: start %b byp %b want 0 0", dev_start, byp_valid); end
        nvec++; if (status !== 32'h0) begin nerr++; $display("FAIL rst_status: got %h want 0", status); end
        nvec++; if (dev_addr !== 32'h0 || dev_snoop !== 4'h0) begin nerr++; $display("FAIL rst_capture: got %h/%h want 0/0", dev_addr, dev_snoop); end
        rst = 1'b0;
        tick();
        nvec++; if (fsm_state !== 3'd0) begin nerr++; $display("FAIL idle_off: got %0d want 0", fsm_state); end
    endtask

    task automatic test_oneshot_delay();
        control_reg = 32'h3; delay_reg = 32'd5;
        tick();
        nvec++; if (fsm_state !== 3'd1 || acready !== 1'b1) begin nerr++; $display("FAIL t1_armed: state %0d acready %b want 1 1", fsm_state, acready); end
        nvec++; if (status !== 32'h1) begin nerr++; $display("FAIL t1_armed_status: got %h want 00000001", status); end
        acvalid = 1'b1; acaddr = 32'h1040; acsnoop = 4'h1;
        tick();
        acvalid = 1'b0;
        nvec++; if (fsm_state !== 3'd2 || acready !== 1'b0) begin nerr++; $display("FAIL t1_delay_entry: state %0d acready %b want 2 0", fsm_state, acready); end
        for (int k = 2; k <= 5; k++) begin
            tick();
            nvec++; if (dev_start !== 1'b0 || fsm_state !== 3'd2) begin nerr++; $display("FAIL t1_delay_c%0d: start %b state %0d want 0 2", k, dev_start, fsm_state); end
        end
        tick();
        nvec++; if (dev_start !== 1'b1 || fsm_state !== 3'd3) begin nerr++; $display("FAIL t1_start: start %b state %0d want 1 3", dev_start, fsm_state); end
        nvec++; if (dev_addr !== 32'h1040 || dev_snoop !== 4'h1) begin nerr++; $display("FAIL t1_dev_addr: got %h/%h want 1040/1", dev_addr, dev_snoop); end
        nvec++; if (status !== 32'h0001_0002) begin nerr++; $display("FAIL t1_busy_status: got %h want 00010002", status); end
        tick();
        nvec++; if (dev_start !== 1'b0 || fsm_state !== 3'd3) begin nerr++; $display("FAIL t1_start_pulse: start %b state %0d want 0 3", dev_start, fsm_state); end
        dev_done = 1'b1;
        tick();
        dev_done = 1'b0;
        nvec++; if (fsm_state !== 3'd5) begin nerr++; $display("FAIL t1_done_state: got %0d want 5", fsm_state); end
        nvec++; if (status !== 32'h0001_0004) begin nerr++; $display("FAIL t1_fired_status: got %h want 00010004", status); end
        tick();
        nvec++; if (fsm_state !== 3'd5 || acready !== 1'b0) begin nerr++; $display("FAIL t1_done_hold: state %0d acready %b want 5 0", fsm_state, acready); end
        control_reg = 32'hB;
        tick();
        control_reg = 32'h0;
        nvec++; if (fsm_state !== 3'd0 || status !== 32'h0) begin nerr++; $display("FAIL t1_clear: state %0d status %h want 0 0", fsm_state, status); end
    endtask

    task automatic test_window_end();
        control_reg = 32'h3;
        tick();
        acvalid = 1'b1; acaddr = 32'h1100; acsnoop = 4'h1;
        tick();
        acvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            nvec++; if (fsm_state !== 3'd4 || byp_valid !== 1'b1 || byp_snoop !== 4'h1) begin nerr++; $display("FAIL t2_bypass_c%0d: state %0d valid %b snoop %h want 4 1 1", i, fsm_state, byp_valid, byp_snoop); end
            nvec++; if (dev_start !== 1'b0) begin nerr++; $display("FAIL t2_no_start_c%0d: got %b want 0", i, dev_start); end
            if (i == 2) byp_ready = 1'b1;
            tick();
        end
        byp_ready = 1'b0;
        nvec++; if (fsm_state !== 3'd1 || byp_valid !== 1'b0 || acready !== 1'b1) begin nerr++; $display("FAIL t2_rearm: state %0d valid %b acready %b want 1 0 1", fsm_state, byp_valid, acready); end
    endtask

    task automatic test_back_to_back();
        control_reg = 32'h5; delay_reg = 32'd0;
        for (int i = 0; i < 3; i++) begin
            acvalid = 1'b1; acaddr = 32'h1000 + 32'(4 * i); acsnoop = 4'h1;
            tick();
            acvalid = 1'b0;
            nvec++; if (fsm_state !== 3'd3 || dev_start !== 1'b1) begin nerr++; $display("FAIL t3_start_%0d: state %0d start %b want 3 1", i, fsm_state, dev_start); end
            nvec++; if (status[31:16] !== 16'(i + 1) || dev_addr !== 32'h1000 + 32'(4 * i)) begin nerr++; $display("FAIL t3_count_%0d: count %0d addr %h want %0d %h", i, status[31:16], dev_addr, i + 1, 32'h1000 + 32'(4 * i)); end
            dev_done = 1'b1;
            tick();
            dev_done = 1'b0;
            nvec++; if (fsm_state !== 3'd1 || dev_start !== 1'b0 || acready !== 1'b1) begin nerr++; $display("FAIL t3_rearm_%0d: state %0d start %b acready %b want 1 0 1", i, fsm_state, dev_start, acready); end
        end
        nvec++; if (status !== 32'h0003_0001) begin nerr++; $display("FAIL t3_status: got %h want 00030001", status); end
        dev_done = 1'b1;
        tick();
        dev_done = 1'b0;
        nvec++; if (fsm_state !== 3'd1 || status !== 32'h0003_0001) begin nerr++; $display("FAIL t3_stray_done: state %0d status %h want 1 00030001", fsm_state, status); end
    endtask

    task automatic test_no_wrap();
        base_reg = 32'hFFFF_FF00; size_reg = 32'h200;
        acvalid = 1'b1; acaddr = 32'h0000_0010; acsnoop = 4'h1;
        tick();
        acvalid = 1'b0; byp_ready = 1'b1;
        nvec++; if (fsm_state !== 3'd4 || byp_valid !== 1'b1) begin nerr++; $display("FAIL t4_nowrap: state %0d valid %b want 4 1", fsm_state, byp_valid); end
        tick();
        byp_ready = 1'b0;
        size_reg = 32'h0; acvalid = 1'b1; acaddr = 32'hFFFF_FF10;
        tick();
        acvalid = 1'b0; byp_ready = 1'b1;
        nvec++; if (fsm_state !== 3'd4) begin nerr++; $display("FAIL t4_size0: state %0d want 4", fsm_state); end
        tick();
        byp_ready = 1'b0;
        size_reg = 32'h200; acvalid = 1'b1; acaddr = 32'hFFFF_FF80; acsnoop = 4'h2;
        tick();
        acvalid = 1'b0; byp_ready = 1'b1;
        nvec++; if (fsm_state !== 3'd4) begin nerr++; $display("FAIL t4_type_miss: state %0d want 4", fsm_state); end
        tick();
        byp_ready = 1'b0;
        acsnoop_reg = 32'h10; acvalid = 1'b1; acaddr = 32'hFFFF_FFF0; acsnoop = 4'h7;
        tick();
        acvalid = 1'b0;
        nvec++; if (fsm_state !== 3'd3 || dev_start !== 1'b1 || dev_snoop !== 4'h7) begin nerr++; $display("FAIL t4_top_hit: state %0d start %b snoop %h want 3 1 7", fsm_state, dev_start, dev_snoop); end
        dev_done = 1'b1;
        tick();
        dev_done = 1'b0;
        control_reg = 32'h8;
        tick();
        control_reg = 32'h0;
        nvec++; if (fsm_state !== 3'd0 || status !== 32'h0) begin nerr++; $display("FAIL t4_clear_idle: state %0d status %h want 0 0", fsm_state, status); end
        base_reg = 32'h1000; size_reg = 32'h100; acsnoop_reg = 32'h1;
    endtask

    task automatic test_abort();
        control_reg = 32'h3; delay_reg = 32'd10;
        tick();
        acvalid = 1'b1; acaddr = 32'h1020; acsnoop = 4'h1;
        tick();
        acvalid = 1'b0;
        tick();
        nvec++; if (fsm_state !== 3'd2 || dev_start !== 1'b0) begin nerr++; $display("FAIL t5_delay: state %0d start %b want 2 0", fsm_state, dev_start); end
        control_reg = 32'h0;
        tick();
        nvec++; if (fsm_state !== 3'd4 || byp_valid !== 1'b1 || dev_start !== 1'b0) begin nerr++; $display("FAIL t5_abort: state %0d valid %b start %b want 4 1 0", fsm_state, byp_valid, dev_start); end
        nvec++; if (status !== 32'h8) begin nerr++; $display("FAIL t5_aborted: got %h want 00000008", status); end
        byp_ready = 1'b1;
        tick();
        byp_ready = 1'b0;
        nvec++; if (fsm_state !== 3'd0 || acready !== 1'b0 || dev_start !== 1'b0) begin nerr++; $display("FAIL t5_idle: state %0d acready %b start %b want 0 0 0", fsm_state, acready, dev_start); end
        control_reg = 32'h8;
        tick();
        control_reg = 32'h0;
        nvec++; if (status !== 32'h0) begin nerr++; $display("FAIL t5_clear: got %h want 0", status); end
    endtask

    task automatic test_reset_midop();
        control_reg = 32'h3; delay_reg = 32'd0;
        tick();
        acvalid = 1'b1; acaddr = 32'h1080; acsnoop = 4'h1;
        tick();
        acvalid = 1'b0;
        nvec++; if (fsm_state !== 3'd3 || dev_start !== 1'b1) begin nerr++; $display("FAIL t6_attack: state %0d start %b want 3 1", fsm_state, dev_start); end
        #2 rst = 1'b1;
        #1;
        nvec++; if (fsm_state !== 3'd0 || dev_start !== 1'b0 || status !== 32'h0 || dev_addr !== 32'h0) begin nerr++; $display("FAIL t6_rst_attack: state %0d start %b status %h addr %h want 0 0 0 0", fsm_state, dev_start, status, dev_addr); end
        tick();
        rst = 1'b0; delay_reg = 32'd5;
        tick();
        acvalid = 1'b1;
        tick();
        acvalid = 1'b0;
        tick();
        nvec++; if (fsm_state !== 3'd2) begin nerr++; $display("FAIL t6_delay: state %0d want 2", fsm_state); end
        #2 rst = 1'b1;
        #1;
        nvec++; if (fsm_state !== 3'd0 || acready !== 1'b0 || byp_valid !== 1'b0) begin nerr++; $display("FAIL t6_rst_delay: state %0d acready %b valid %b want 0 0 0", fsm_state, acready, byp_valid); end
        tick();
        rst = 1'b0; control_reg = 32'h5; delay_reg = 32'd0;
        tick();
        acvalid = 1'b1;
        tick();
        acvalid = 1'b0; dev_done = 1'b1;
        tick();
        dev_done = 1'b0;
        nvec++; if (status !== 32'h0001_0001) begin nerr++; $display("FAIL t6_pre_clear: got %h want 00010001", status); end
        acvalid = 1'b1; control_reg = 32'hD;
        tick();
        acvalid = 1'b0; control_reg = 32'h5;
        nvec++; if (dev_start !== 1'b1 || status !== 32'h0000_0002) begin nerr++; $display("FAIL t6_clear_wins: start %b status %h want 1 00000002", dev_start, status); end
        dev_done = 1'b1;
        tick();
        dev_done = 1'b0; control_reg = 32'h0;
        tick();
        nvec++; if (fsm_state !== 3'd0 || status !== 32'h0) begin nerr++; $display("FAIL t6_end: state %0d status %h want 0 0", fsm_state, status); end
    endtask

    initial begin
        test_reset();
        test_oneshot_delay();
        test_window_end();
        test_back_to_back();
        test_no_wrap();
        test_abort();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
